// File: rtl/mem_bridge_if.sv
// CPU-side and memory-side signal bundle for mem_bridge.
// The "slave" modport is the bridge itself (it serves the CPU and drives the
// memory bus). The "master" modport is the environment: the CPU plus the
// external memory.
interface mem_bridge_if;
  // CPU side
  logic        cpu_req;
  logic        memwrite;
  logic [31:0] adr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        cpu_ready;
  // memory side
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        bus_err;

  modport slave (
    input  cpu_req, memwrite, adr, writedata, mem_rdata, mem_ack,
    output readdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata, bus_err
  );

  modport master (
    output cpu_req, memwrite, adr, writedata, mem_rdata, mem_ack,
    input  readdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata, bus_err
  );
endinterface

// File: rtl/mem_bridge.sv
// CPU-to-memory bridge.
// - Writes are posted into a small FIFO and acknowledged to the CPU in the
//   same cycle they are presented.
// - Reads stall the CPU until the FIFO has drained, so a load never overtakes
//   an older store.
// - Every memory transaction is guarded by a wait counter. On expiry the
//   transaction is aborted and a sticky bus_err flag is raised.
module mem_bridge #(
  parameter int WBUF_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input logic         clk,
  input logic         reset,
  mem_bridge_if.slave bus
);

  localparam int             AW       = $clog2(WBUF_DEPTH);
  localparam logic [7:0]     TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [31:0]    ABORT_RD = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
  } wentry_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_ISSUE = 2'd1,
    RD_ISSUE = 2'd2,
    RD_DONE  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  wentry_t     wbuf [WBUF_DEPTH];
  wentry_t     head;
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, push, pop;
  logic        issuing, timeout_hit;
  logic [7:0]  wait_cnt;

  // adr[1:0] selects a byte within the word and has no role on a word bus.
  logic unused_adr_lsb;
  assign unused_adr_lsb = ^bus.adr[1:0];

  // Pointers carry one extra wrap bit. Full means the indices match while
  // the wrap bits differ.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = wbuf[rd_ptr[AW-1:0]];

  assign issuing     = (state == WR_ISSUE) || (state == RD_ISSUE);
  assign timeout_hit = issuing && !bus.mem_ack && (wait_cnt == TMO_LAST);

  // Full is judged on the pre-edge occupancy, so a pop on this edge does not
  // free a slot for a write in the same cycle.
  assign push = bus.cpu_req && bus.memwrite && !full;
  // A timed-out write is dropped, so that one bad address cannot wedge the
  // buffer.
  assign pop  = (state == WR_ISSUE) && (bus.mem_ack || timeout_hit);

  // Write buffer storage. It has no reset: the pointers decide which entries
  // are valid.
  always_ff @(posedge clk) begin
    if (push) wbuf[wr_ptr[AW-1:0]] <= '{addr: bus.adr[31:2], data: bus.writedata};
  end

  // Write buffer pointers. Reset empties the buffer and discards any posted
  // writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and the memory/CPU handshake outputs.
  // mem_addr and mem_wdata are forced to zero whenever no request is
  // outstanding. In RD_ISSUE the address comes straight from the CPU, which
  // holds adr stable until cpu_ready.
  always_comb begin
    state_nxt     = state;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.cpu_ready = push;
    case (state)
      IDLE: begin
        if (!empty)                              state_nxt = WR_ISSUE;
        else if (bus.cpu_req && !bus.memwrite)   state_nxt = RD_ISSUE;
      end
      WR_ISSUE: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = head.addr;
        bus.mem_wdata = head.data;
        if (pop) state_nxt = IDLE;
      end
      RD_ISSUE: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = bus.adr[31:2];
        if (bus.mem_ack || timeout_hit) state_nxt = RD_DONE;
      end
      RD_DONE: begin
        bus.cpu_ready = 1'b1;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Wait counter. It is zero outside the issue states, so it is always clear
  // on entry to an issue state. It counts each issue cycle without an ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                           wait_cnt <= '0;
    else if (!issuing)                    wait_cnt <= '0;
    else if (bus.mem_ack || timeout_hit)  wait_cnt <= '0;
    else                                  wait_cnt <= wait_cnt + 8'd1;
  end

  // Load data register. It holds its value until the next read completes or
  // aborts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                       bus.readdata <= '0;
    else if (state == RD_ISSUE && bus.mem_ack)        bus.readdata <= bus.mem_rdata;
    else if (state == RD_ISSUE && timeout_hit)        bus.readdata <= ABORT_RD;
  end

  // Sticky bus error flag. Only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           bus.bus_err <= 1'b0;
    else if (timeout_hit) bus.bus_err <= 1'b1;
  end

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 Parameter WBUF_DEPTH, default 4 (power of 2, >=2): posted-write buffer entries.
REQ-002 Parameter TIMEOUT, default 255: max cycles waiting for mem_ack before abort.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  reset is asynchronous and active-low.
REQ-005 cpu_req  input  1  CPU access valid; held with adr/memwrite/writedata stable until cpu_ready=1.
REQ-006 memwrite  input  1  1 = write, 0 = read.
REQ-007 adr  input  32  CPU byte address; adr[1:0] ignored.
REQ-008 writedata  input  32  CPU store data.
REQ-009 readdata  output  32  load data returned to CPU.
REQ-010 cpu_ready  output  1  access complete/accepted this cycle.
REQ-011 mem_req  output  1  external memory request.
REQ-012 mem_we  output  1  external write enable, valid with mem_req.
REQ-013 mem_addr  output  30  word address (adr[31:2]).
REQ-014 mem_wdata  output  32  external write data.
REQ-015 mem_rdata  input  32  external read data, valid when mem_ack=1 on a read.
REQ-016 mem_ack  input  1  external completion, one-cycle pulse.
REQ-017 bus_err  output  1  sticky timeout flag.

Function
REQ-018 Writes posted: cpu_req&memwrite&!full -> cpu_ready=1 combinationally same cycle; {adr[31:2],writedata} pushed at edge.
REQ-019 Buffer full -> write cpu_ready=0 until an entry drains; no entry lost or overwritten.
REQ-020 Push and pop on same edge: count unchanged, FIFO order preserved; full evaluated on pre-edge count.
REQ-021 FSM states IDLE, WR_ISSUE, RD_ISSUE, RD_DONE, encoded in 2 bits.
REQ-022 IDLE: buffer non-empty -> WR_ISSUE; else cpu_req&!memwrite -> RD_ISSUE; else stay.
REQ-023 WR_ISSUE: mem_req=1, mem_we=1, mem_addr/mem_wdata = head; mem_ack -> pop, -> IDLE.
REQ-024 Reads never bypass buffered writes: read issued only with buffer empty (strict RAW order).
REQ-025 RD_ISSUE: mem_req=1, mem_we=0, mem_addr=adr[31:2]; mem_ack -> capture mem_rdata into readdata, -> RD_DONE.
REQ-026 RD_DONE: cpu_ready=1 for exactly one cycle, -> IDLE; read latency = ack cycle + 1.
REQ-027 readdata holds last captured value until next read completes.
REQ-028 mem_req and all mem_* fields stable from assertion until the mem_ack cycle; mem_ack same cycle as mem_req assertion legal.
REQ-029 mem_ack in IDLE or RD_DONE ignored.
REQ-030 8-bit wait counter cleared on entering WR_ISSUE/RD_ISSUE, increments each issue cycle without ack.
REQ-031 Counter reaching TIMEOUT without ack: bus_err=1, abort (write: pop entry; read: readdata=32'hDEADBEEF, -> RD_DONE).
REQ-032 bus_err cleared only by reset.
REQ-033 mem_req=0 in IDLE and RD_DONE; cpu_ready=0 except per REQ-018/026.

Reset
REQ-034 reset=0 asynchronously: state IDLE, buffer empty, counter 0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, readdata=0, cpu_ready=0, bus_err=0.
REQ-035 Reset mid-transaction: mem_req drops immediately; buffered writes discarded; late mem_ack after release ignored.
REQ-036 First edge after reset release behaves as IDLE.

Verification
REQ-037 Write adr=0x40, data=0x1234_5678, ack 2 cycles after req -> cpu_ready same cycle; mem_addr=0x10, mem_wdata=0x12345678, mem_we=1.
REQ-038 5 back-to-back writes, mem_ack withheld -> 4 accepted, 5th stalls cpu_ready=0 until first ack, then accepted; memory sees writes in order.
REQ-039 Write 0xAAAA_AAAA to 0x80 then read 0x80 -> write acked before read mem_req; readdata = mem_rdata, cpu_ready one cycle after read ack.
REQ-040 Read with mem_ack same cycle as mem_req -> cpu_ready next cycle, total 2 cycles.
REQ-041 Read, mem_ack never asserted -> after 255 cycles bus_err=1, readdata=0xDEADBEEF, cpu_ready pulse, bus_err stays 1.
REQ-042 reset low during WR_ISSUE with 3 entries -> mem_req=0 without clock edge; after release buffer empty, no write issued.
